// File: rtl/wb_design_router.sv
// Wishbone front-end: registers each request, routes it to the mux control regs or the selected design.
// Latency: target strobe 1 cycle after the request; upstream ack 1 cycle after target ack (unmapped: 1 cycle).
// Backpressure: one transaction at a time; a watchdog aborts unresponsive slaves with an error word.
module wb_design_router #(
    parameter int          NUM_DESIGNS    = 3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic                      wbs_we_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_ack_o,
    input  logic [3:0]                design_select,
    output logic                      mux_cyc_o,
    output logic                      mux_stb_o,
    input  logic [31:0]               mux_dat_i,
    input  logic                      mux_ack_i,
    output logic [31:0]               fwd_adr_o,
    output logic [31:0]               fwd_dat_o,
    output logic [3:0]                fwd_sel_o,
    output logic                      fwd_we_o,
    output logic [NUM_DESIGNS-1:0]    dsn_cyc_o,
    output logic [NUM_DESIGNS-1:0]    dsn_stb_o,
    input  logic [32*NUM_DESIGNS-1:0] dsn_dat_i,
    input  logic [NUM_DESIGNS-1:0]    dsn_ack_i,
    output logic [7:0]                timeout_count,
    output logic                      err_o
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_RESP, S_DROP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             fwd_adr_q, fwd_adr_d;
    logic [31:0]             fwd_dat_q, fwd_dat_d;
    logic [3:0]              fwd_sel_q, fwd_sel_d;
    logic                    fwd_we_q, fwd_we_d;
    logic                    mux_stb_q, mux_stb_d;
    logic [NUM_DESIGNS-1:0]  dsn_stb_q, dsn_stb_d;
    logic [WDW-1:0]          wd_q, wd_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [31:0]             dat_q, dat_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic [NUM_DESIGNS-1:0]  dsn_hit;
    logic                    tgt_ack;
    logic [31:0]             tgt_dat;

    // One-hot decode of design_select (values 1..NUM_DESIGNS) to a design port.
    always_comb begin
        dsn_hit = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            dsn_hit[i] = (design_select == 4'(i + 1));
        end
    end

    // The active strobe identifies the latched target, so only its ack/data pass through.
    always_comb begin
        tgt_ack = mux_stb_q & mux_ack_i;
        tgt_dat = mux_stb_q ? mux_dat_i : 32'h0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            if (dsn_stb_q[i]) begin
                tgt_ack = tgt_ack | dsn_ack_i[i];
                tgt_dat = tgt_dat | dsn_dat_i[32*i +: 32];
            end
        end
    end

    // Next-state and output logic for the request/forward/response sequence.
    always_comb begin
        state_d   = state_q;
        fwd_adr_d = fwd_adr_q;
        fwd_dat_d = fwd_dat_q;
        fwd_sel_d = fwd_sel_q;
        fwd_we_d  = fwd_we_q;
        mux_stb_d = mux_stb_q;
        dsn_stb_d = dsn_stb_q;
        wd_d      = wd_q;
        tmo_d     = tmo_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    fwd_adr_d = wbs_adr_i;
                    fwd_dat_d = wbs_dat_i;
                    fwd_sel_d = wbs_sel_i;
                    fwd_we_d  = wbs_we_i;
                    wd_d      = '0;
                    if (wbs_adr_i[20]) begin
                        mux_stb_d = 1'b1;
                        state_d   = S_FWD;
                    end else if (|dsn_hit) begin
                        dsn_stb_d = dsn_hit;
                        state_d   = S_FWD;
                    end else begin
                        dat_d   = 32'hFFFF_FFFF;
                        err_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_FWD: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: release the slave silently.
                    mux_stb_d = 1'b0;
                    dsn_stb_d = '0;
                    state_d   = S_IDLE;
                end else if (tgt_ack) begin
                    // An ack on the final watchdog cycle still wins over the timeout.
                    dat_d     = tgt_dat;
                    mux_stb_d = 1'b0;
                    dsn_stb_d = '0;
                    ack_d     = 1'b1;
                    state_d   = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    dat_d     = TIMEOUT_DATA;
                    mux_stb_d = 1'b0;
                    dsn_stb_d = '0;
                    err_d     = 1'b1;
                    ack_d     = 1'b1;
                    if (tmo_q != 8'hFF) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                    state_d   = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_DROP;
            end
            S_DROP: begin
                // Hold off until the master releases the strobe so it is not seen twice.
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            fwd_adr_q <= '0;
            fwd_dat_q <= '0;
            fwd_sel_q <= '0;
            fwd_we_q  <= 1'b0;
            mux_stb_q <= 1'b0;
            dsn_stb_q <= '0;
            wd_q      <= '0;
            tmo_q     <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fwd_adr_q <= fwd_adr_d;
            fwd_dat_q <= fwd_dat_d;
            fwd_sel_q <= fwd_sel_d;
            fwd_we_q  <= fwd_we_d;
            mux_stb_q <= mux_stb_d;
            dsn_stb_q <= dsn_stb_d;
            wd_q      <= wd_d;
            tmo_q     <= tmo_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign wbs_dat_o     = dat_q;
    assign wbs_ack_o     = ack_q;
    assign mux_cyc_o     = mux_stb_q;
    assign mux_stb_o     = mux_stb_q;
    assign dsn_cyc_o     = dsn_stb_q;
    assign dsn_stb_o     = dsn_stb_q;
    assign fwd_adr_o     = fwd_adr_q;
    assign fwd_dat_o     = fwd_dat_q;
    assign fwd_sel_o     = fwd_sel_q;
    assign fwd_we_o      = fwd_we_q;
    assign timeout_count = tmo_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_wb_design_router.sv
// Bench for wb_design_router: scoreboard of expected upstream responses, slave models with programmable latency.
// Latency: checks exact ack cycle per transaction.
// Backpressure: slaves ack after a configured delay or never (watchdog path).
module tb_wb_design_router;

    localparam int N = 3;
    localparam int TMO = 255;

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic [31:0]     wbs_adr_i, wbs_dat_i;
    logic [3:0]      wbs_sel_i;
    logic            wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [31:0]     wbs_dat_o;
    logic            wbs_ack_o;
    logic [3:0]      design_select;
    logic            mux_cyc_o, mux_stb_o, mux_ack_i;
    logic [31:0]     mux_dat_i;
    logic [31:0]     fwd_adr_o, fwd_dat_o;
    logic [3:0]      fwd_sel_o;
    logic            fwd_we_o;
    logic [N-1:0]    dsn_cyc_o, dsn_stb_o, dsn_ack_i;
    logic [32*N-1:0] dsn_dat_i;
    logic [7:0]      timeout_count;
    logic            err_o;

    always #5 clk = ~clk;

    wb_design_router #(.NUM_DESIGNS(N), .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .design_select(design_select),
        .mux_cyc_o(mux_cyc_o), .mux_stb_o(mux_stb_o), .mux_dat_i(mux_dat_i), .mux_ack_i(mux_ack_i),
        .fwd_adr_o(fwd_adr_o), .fwd_dat_o(fwd_dat_o), .fwd_sel_o(fwd_sel_o), .fwd_we_o(fwd_we_o),
        .dsn_cyc_o(dsn_cyc_o), .dsn_stb_o(dsn_stb_o), .dsn_dat_i(dsn_dat_i), .dsn_ack_i(dsn_ack_i),
        .timeout_count(timeout_count), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          edge_n;
        logic [7:0]  tmo;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          lat[4] = '{-1, -1, -1, -1};
    logic [31:0] sdata[4];
    int          cnt[4] = '{0, 0, 0, 0};
    bit          noise_en = 1'b0;
    int          tmo_model = 0;
    logic [3:0]  exp_oh = 4'b0;
    logic [31:0] exp_adr, exp_wdat;
    logic [3:0]  exp_sel;
    logic        exp_we;

    // Slave index 0 is the mux, 1..N are the design ports.
    wire  [3:0]  stb_all = {dsn_stb_o, mux_stb_o};
    wire  [3:0]  cyc_all = {dsn_cyc_o, mux_cyc_o};
    logic [3:0]  ack_all = 4'b0;
    logic [31:0] dat_all[4];

    assign mux_ack_i = ack_all[0];
    assign dsn_ack_i = ack_all[3:1];
    assign mux_dat_i = dat_all[0];
    assign dsn_dat_i = {dat_all[3], dat_all[2], dat_all[1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Slave models: ack lat cycles after the strobe first appears; random data except on the ack cycle.
    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 4; s++) begin
            if (stb_all[s]) cnt[s] = cnt[s] + 1;
            else            cnt[s] = 0;
            if (stb_all[s] && lat[s] >= 0 && cnt[s] == lat[s] + 1) begin
                ack_all[s] = 1'b1;
                dat_all[s] = sdata[s];
            end else begin
                ack_all[s] = (!stb_all[s] && noise_en) ? ($urandom_range(3) == 0) : 1'b0;
                dat_all[s] = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every upstream ack and checks downstream routing.
    always @(negedge clk) begin
        exp_t e;
        if (!wb_rst_i) begin
            if (wbs_ack_o) begin
                chk("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rdata", wbs_dat_o, e.dat);
                    chk("ack_cycle", edge_cnt, e.edge_n);
                    chk("err_with_ack", 32'(err_o), 32'(e.err));
                    chk("timeout_count", 32'(timeout_count), 32'(e.tmo));
                end
            end else if (err_o) begin
                chk("err_without_ack", 32'(err_o), 32'd0);
            end
            if (stb_all != 4'b0) begin
                chk("stb_target", 32'(stb_all), 32'(exp_oh));
                chk("cyc_eq_stb", 32'(cyc_all), 32'(stb_all));
                chk("fwd_adr", fwd_adr_o, exp_adr);
                chk("fwd_dat", fwd_dat_o, exp_wdat);
                chk("fwd_sel_we", 32'({fwd_sel_o, fwd_we_o}), 32'({exp_sel, exp_we}));
            end
        end
    end

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                             input logic we, input logic [3:0] dsel);
        exp_adr = adr; exp_wdat = wdat; exp_sel = sel; exp_we = we;
        wbs_adr_i = adr; wbs_dat_i = wdat; wbs_sel_i = sel; wbs_we_i = we;
        design_select = dsel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    endtask

    task automatic wait_done(input int mid_dsel);
        int waited = 0;
        while (sb.size() != 0 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
            if (waited == 2 && mid_dsel >= 0) design_select = 4'(mid_dsel);
        end
        chk("txn_completes", 32'(sb.size() == 0), 32'd1);
        sb.delete();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference model: routing from address bit 20 and design_select, response from slave latency.
    task automatic run_txn(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                           input logic we, input logic [3:0] dsel, input int tlat,
                           input int mid_dsel, input logic [31:0] rdat);
        int   tgt;
        bit   expired;
        exp_t e;
        @(posedge clk); #1;
        if (adr[20])                      tgt = 0;
        else if (dsel >= 1 && dsel <= N)  tgt = int'(dsel);
        else                              tgt = -1;
        expired = (tlat < 0) || (tlat + 1 > TMO);
        exp_oh = (tgt >= 0) ? 4'(1 << tgt) : 4'b0;
        if (tgt >= 0) begin
            lat[tgt] = tlat;
            sdata[tgt] = rdat;
        end
        if (tgt < 0) begin
            e.dat = 32'hFFFF_FFFF; e.err = 1'b1; e.edge_n = edge_cnt + 1;
        end else if (expired) begin
            e.dat = 32'hDEADBEEF; e.err = 1'b1; e.edge_n = edge_cnt + 1 + TMO;
            if (tmo_model < 255) tmo_model++;
        end else begin
            e.dat = rdat; e.err = 1'b0; e.edge_n = edge_cnt + 1 + tlat + 1;
        end
        e.tmo = 8'(tmo_model);
        sb.push_back(e);
        drive_req(adr, wdat, sel, we, dsel);
        wait_done(mid_dsel);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dat"}, wbs_dat_o, 32'h0);
        chk({tag, "_ctl"}, 32'({wbs_ack_o, err_o, mux_cyc_o, mux_stb_o, dsn_cyc_o, dsn_stb_o, timeout_count}), 32'h0);
        chk({tag, "_fwd_adr"}, fwd_adr_o, 32'h0);
        chk({tag, "_fwd_dat"}, fwd_dat_o, 32'h0);
        chk({tag, "_fwd_sel_we"}, 32'({fwd_sel_o, fwd_we_o}), 32'h0);
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        exp_t e;
        wb_rst_i = 1'b1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; design_select = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        wb_rst_i = 1'b0;

        // Mux register read, ack 3 cycles after strobe.
        run_txn(32'h3010_0004, 32'h0, 4'hF, 1'b0, 4'd1, 3, -1, 32'h0000_00C5);
        // Design 2 write with a mid-transaction design_select change.
        run_txn(32'h3000_0010, 32'hA5A5_0001, 4'hF, 1'b1, 4'd2, 4, 3, 32'h1234_5678);
        // Unmapped access.
        run_txn(32'h3000_0000, 32'h0, 4'hF, 1'b0, 4'd0, 2, -1, 32'h0);
        run_txn(32'h3000_0000, 32'h0, 4'h3, 1'b0, 4'd4, 2, -1, 32'h0);
        // Zero-latency slave.
        run_txn(32'h3000_0020, 32'h0, 4'hF, 1'b0, 4'd3, 0, -1, 32'hCAFE_0003);
        // Ack on the last watchdog cycle wins; one cycle later times out.
        run_txn(32'h3000_0030, 32'h0, 4'hF, 1'b0, 4'd1, TMO - 1, -1, 32'h0BAD_F00D);
        run_txn(32'h3000_0030, 32'h0, 4'hF, 1'b0, 4'd1, TMO, -1, 32'h0BAD_F00D);
        // Saturating timeout counter.
        for (int i = 0; i < 256; i++) begin
            run_txn(32'h3000_0040, 32'h0, 4'hF, 1'b0, 4'd1, -1, -1, 32'h0);
        end
        chk("tmo_saturated", 32'(timeout_count), 32'd255);

        // Master drops cyc during FWD: silent abort.
        @(posedge clk); #1;
        lat[2] = -1;
        exp_oh = 4'b0100;
        drive_req(32'h3000_0050, 32'h5555_AAAA, 4'h1, 1'b1, 4'd2);
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_stb_before", 32'(stb_all), 32'(exp_oh));
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_stb_after", 32'(stb_all), 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_tmo", 32'(timeout_count), 32'(tmo_model));
        run_txn(32'h3000_0060, 32'h0, 4'hF, 1'b0, 4'd2, 1, -1, 32'h600D_0002);

        // Randomized traffic with ack noise on idle slaves.
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_txn($urandom, $urandom, 4'($urandom), 1'($urandom), 4'($urandom_range(0, 4)),
                    ($urandom_range(15) == 0) ? -1 : int'($urandom_range(0, 6)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(0, 4)) : -1, $urandom);
        end
        noise_en = 1'b0;

        // Reset during FWD with strobe held through it.
        @(posedge clk); #1;
        lat[1] = -1;
        exp_oh = 4'b0010;
        drive_req(32'h3000_0070, 32'h7777_0000, 4'hF, 1'b0, 4'd1);
        repeat (5) begin @(posedge clk); #1; end
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        check_zero("fwd_reset");
        tmo_model = 0;
        lat[1] = 2;
        sdata[1] = 32'h0A0B_0C0D;
        e.dat = 32'h0A0B_0C0D; e.err = 1'b0; e.edge_n = edge_cnt + 1 + 3; e.tmo = 8'd0;
        sb.push_back(e);
        wb_rst_i = 1'b0;
        wait_done(-1);
        repeat (6) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
